spi_prefetch_fetch: RTL and testbench
=====================================

# spi_prefetch_fetch

Instruction/operand fetch unit between the 6-bit core and the external SPI NOR flash (command 0x03 READ, SPI mode 0). It accepts 12-bit byte-address requests from the core, keeps a small FIFO of sequentially prefetched bytes, and answers hits in one cycle. On a miss it restarts the flash read at the new address. Only the low 6 bits of each flash byte are returned.

## Interface
- DEPTH, 4: prefetch FIFO entries; power of two, 2..8
- ADDR_W, 12: request address width
- DATA_W, 6: returned data width; always the low DATA_W bits of each flash byte
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- double_speed  in  1  1: one SPI phase per clk; 0: one SPI phase per 2 clk
- req_valid  in  1  fetch request; held with stable req_addr until rsp_valid
- req_addr  in  ADDR_W  byte address requested
- rsp_valid  out  1  one-cycle pulse; rsp_data valid
- rsp_data  out  DATA_W  fetched data; holds its value until the next rsp_valid
- cs_rom  out  1  flash chip select, active low
- sclk_rom  out  1  flash clock, idles low
- rom_do  out  1  MOSI
- rom_di  in  1  MISO
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy (debug)

## Operation
- State: head_addr (address of the FIFO head byte), count, stream_addr (address of the byte being shifted in), and stream FSM IDLE → DESEL → CMD → ADDR → DATA → PAUSE.
- Hit: req_valid & count>0 & req_addr==head_addr. Response is rsp_data = head[DATA_W-1:0] and rsp_valid=1 next cycle. The entry is popped and head_addr increments.
- Wait: req_valid & count==0 & req_addr==stream_addr & FSM in CMD/ADDR/DATA/PAUSE. No action; the block waits for the byte.
- Miss (any other req_valid case): flush the FIFO and abort any partial byte. Set head_addr=stream_addr=req_addr and go to DESEL.
- req_valid is ignored in the cycle rsp_valid is high. The requester updates req_valid/req_addr on that edge.
- DESEL: cs_rom=1, sclk_rom=0 for exactly 2 clk, then CMD with cs_rom=0.
- CMD/ADDR shift 32 bits MSB first: 0x03, 0x00, {4'h0, addr[11:8]}, addr[7:0].
- DATA: shifts 8 bits per byte. The completed byte is pushed and stream_addr increments.
- Bit timing: each bit is a low phase then a high phase. rom_do changes at entry to the low phase. rom_di is sampled on the clk edge that drives sclk_rom low (end of high phase).
- PAUSE is entered when count==DEPTH after a push. It is also entered when the byte just pushed was at address 2^ADDR_W-1, so there is no wrap; a request for 0 then misses. In PAUSE: cs_rom stays 0, sclk_rom holds 0, and no bits are shifted. Return to DATA once count<DEPTH; wrap-paused state never resumes.
- Push and pop in the same cycle leave count unchanged.
- A miss during PAUSE or mid-byte restarts via DESEL. No stale byte may be pushed after a flush.
- rst (any cycle, including mid-transfer):
  - cs_rom=1, sclk_rom=0, rom_do=0
  - rsp_valid=0, rsp_data=0, count=0
  - head_addr=stream_addr=0, FSM=IDLE
- IDLE → DESEL only on a miss.

## Timing
- Phase length k = 1 clk (double_speed=1) or 2 clk (double_speed=0). double_speed is sampled at each phase boundary.
- Hit latency: rsp_valid in the cycle after req_valid is first evaluated high.
- Miss latency from request cycle C to rsp_valid: C+4+80k (84 or 164 cycles). This is 2 DESEL, 40 bits × 2 phases × k, 1 push and 1 response cycle.
- Streaming throughput once open: one byte per 16k clk. Sequential fetches keep the FIFO full when the core consumes slower than this.
- cs_rom rises only in DESEL or reset; never toggles while sclk_rom=1.

## Test plan
- Cold miss, double_speed=1, flash byte 0x3 at addr 0x123 = 0xA5 → cs low after 2 cycles; MOSI stream 03 00 01 23; rsp_valid at C+84 with rsp_data=0x25.
- Sequential fetch 0x200..0x20F at double_speed=0 → one miss, 15 hits; each hit 1-cycle latency once filled; fifo_level never exceeds 4; data matches flash model.
- Full FIFO, no requests for 500 cycles → sclk_rom stays low, cs_rom low, fifo_level=4; next request head_addr hits; streaming resumes within 2k cycles.
- Jump: mid-byte request for 0x7FF while streaming 0x100 → cs_rom high exactly 2 cycles; new address 00 07 FF sent; rsp_data=flash[0x7FF][5:0]; no byte from 0x10x returned.
- Wrap: sequential fetch to 0xFFF then request 0x000 → PAUSE after 0xFFF, then a miss with new 03 00 00 00 command.
- Reset asserted during ADDR phase → next cycle cs_rom=1, sclk_rom=0, rom_do=0, rsp_valid=0, fifo_level=0; first request afterwards behaves as a cold miss.

Source files
------------

// File: rtl/spi_prefetch_fetch.sv
// Fetch unit between the core and a SPI NOR flash (READ 0x03, mode 0).
// Serves requests from a small prefetch FIFO; misses restart the flash read stream.
module spi_prefetch_fetch #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     double_speed,
  input  logic                     req_valid,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     cs_rom,
  output logic                     sclk_rom,
  output logic                     rom_do,
  input  logic                     rom_di,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: a request is held with a stable address until rsp_valid pulses;
  // it is ignored during the rsp_valid cycle and may change on the edge ending it.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DESEL = 3'd1,
    S_CMD   = 3'd2,
    S_ADDR  = 3'd3,
    S_DATA  = 3'd4,
    S_PAUSE = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_head_addr;
  logic [ADDR_W-1:0]   r_stream_addr;
  logic [CNT_W-1:0]    r_count;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic [31:0]         r_tx;
  logic [DATA_W-2:0]   r_rx;
  logic [4:0]          r_bit_cnt;
  logic                r_phase;
  logic                r_sub;
  logic                r_slow;
  logic                r_desel_cnt;
  logic                r_wrap;

  logic                w_phase_end;
  logic                w_shifting;
  logic                w_bit_end;
  logic                w_bit_last;
  logic                w_req_live;
  logic                w_streaming;
  logic                w_hit;
  logic                w_wait;
  logic                w_miss;
  logic                w_push;
  logic                w_pop;
  logic                w_last_addr;
  logic [CNT_W-1:0]    w_count_next;
  logic [DATA_W-1:0]   w_byte;

  always_comb begin
    w_phase_end  = ~r_slow | r_sub;
    w_shifting   = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_DATA);
    w_bit_end    = w_shifting & r_phase & w_phase_end;
    w_bit_last   = (r_state == S_ADDR) ? (r_bit_cnt == 5'd23) : (r_bit_cnt == 5'd7);
    w_req_live   = req_valid & ~r_rsp_valid;
    // DESEL counts as streaming so the held request that caused a miss does not re-trigger it.
    w_streaming  = (r_state == S_DESEL) || w_shifting || ((r_state == S_PAUSE) && !r_wrap);
    w_hit        = w_req_live && (r_count != '0) && (req_addr == r_head_addr);
    w_wait       = w_req_live && (r_count == '0) && (req_addr == r_stream_addr) && w_streaming;
    w_miss       = w_req_live & ~w_hit & ~w_wait;
    w_pop        = w_hit;
    w_push       = ~w_miss && (r_state == S_DATA) && w_bit_end && (r_bit_cnt == 5'd7);
    w_last_addr  = &r_stream_addr;
    w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    w_byte       = {r_rx, rom_di};
  end

  always_comb begin
    w_state_next = r_state;
    if (w_miss) begin
      w_state_next = S_DESEL;
    end else begin
      case (r_state)
        S_IDLE:  w_state_next = S_IDLE;
        S_DESEL: if (r_desel_cnt) w_state_next = S_CMD;
        S_CMD:   if (w_bit_end && w_bit_last) w_state_next = S_ADDR;
        S_ADDR:  if (w_bit_end && w_bit_last) w_state_next = S_DATA;
        S_DATA:  if (w_push && ((w_count_next == CNT_W'(DEPTH)) || w_last_addr))
                   w_state_next = S_PAUSE;
        S_PAUSE: if (!r_wrap && (r_count < CNT_W'(DEPTH))) w_state_next = S_DATA;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= w_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head_addr   <= '0;
      r_stream_addr <= '0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_tx          <= '0;
      r_rx          <= '0;
      r_bit_cnt     <= '0;
      r_phase       <= 1'b0;
      r_sub         <= 1'b0;
      r_slow        <= 1'b0;
      r_desel_cnt   <= 1'b0;
      r_wrap        <= 1'b0;
    end else begin
      r_rsp_valid <= w_hit;
      if (w_hit) r_rsp_data <= r_mem[r_rd_ptr];
      if (w_miss) begin
        r_head_addr   <= req_addr;
        r_stream_addr <= req_addr;
        r_count       <= '0;
        r_rd_ptr      <= '0;
        r_wr_ptr      <= '0;
        r_tx          <= {8'h03, {(24-ADDR_W){1'b0}}, req_addr};
        r_bit_cnt     <= '0;
        r_phase       <= 1'b0;
        r_sub         <= 1'b0;
        r_desel_cnt   <= 1'b0;
        r_wrap        <= 1'b0;
      end else begin
        r_count <= w_count_next;
        if (w_pop) begin
          r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
          r_head_addr <= r_head_addr + ADDR_W'(1);
        end
        if (w_push) begin
          r_wr_ptr      <= r_wr_ptr + PTR_W'(1);
          r_stream_addr <= r_stream_addr + ADDR_W'(1);
          if (w_last_addr) r_wrap <= 1'b1;
        end
        case (r_state)
          S_DESEL: begin
            r_desel_cnt <= 1'b1;
            r_phase     <= 1'b0;
            r_sub       <= 1'b0;
            r_slow      <= ~double_speed;
            r_bit_cnt   <= '0;
          end
          S_CMD, S_ADDR, S_DATA: begin
            if (w_phase_end) begin
              // Phase length is re-sampled at every phase boundary.
              r_sub   <= 1'b0;
              r_phase <= ~r_phase;
              r_slow  <= ~double_speed;
              if (r_phase) begin
                r_tx      <= {r_tx[30:0], 1'b0};
                r_rx      <= w_byte[DATA_W-2:0];
                r_bit_cnt <= w_bit_last ? 5'd0 : r_bit_cnt + 5'd1;
              end
            end else begin
              r_sub <= 1'b1;
            end
          end
          S_PAUSE: begin
            r_phase <= 1'b0;
            r_sub   <= 1'b0;
            r_slow  <= ~double_speed;
          end
          default: ;
        endcase
      end
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign cs_rom     = (r_state == S_IDLE) || (r_state == S_DESEL);
  assign sclk_rom   = w_shifting & r_phase;
  assign rom_do     = r_tx[31];
  assign fifo_level = r_count;

endmodule

// File: tb/tb_spi_prefetch_fetch.sv
// Directed bench for spi_prefetch_fetch: a behavioural SPI flash, a fetch vector
// table and hand sequences for pause, wrap and reset corner cases.
module tb_spi_prefetch_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        double_speed;
  logic        req_valid;
  logic [11:0] req_addr;
  logic        rsp_valid;
  logic [5:0]  rsp_data;
  logic        cs_rom;
  logic        sclk_rom;
  logic        rom_do;
  logic        rom_di = 1'b0;
  logic [2:0]  fifo_level;

  spi_prefetch_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .double_speed (double_speed),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .cs_rom       (cs_rom),
    .sclk_rom     (sclk_rom),
    .rom_do       (rom_do),
    .rom_di       (rom_di),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  // Flash model: captures 32 command/address bits on rising sclk, shifts data out on falling sclk.
  logic [7:0]  flash [0:4095];
  int          fbits = 0;
  logic [31:0] fcmd = '0;
  logic [31:0] cmd_q [$];
  int          fn;
  logic [11:0] fa;
  logic [7:0]  fbyte;

  always @(posedge cs_rom or posedge sclk_rom) begin
    if (cs_rom) begin
      fbits = 0;
    end else begin
      if (fbits < 32) begin
        fcmd = {fcmd[30:0], rom_do};
        if (fbits == 31) cmd_q.push_back(fcmd);
      end
      fbits++;
    end
  end

  always @(negedge sclk_rom) begin
    if (!cs_rom && fbits >= 32) begin
      fn    = fbits - 32;
      fa    = fcmd[11:0] + 12'(fn / 8);
      fbyte = flash[fa];
      rom_di = fbyte[7 - (fn % 8)];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int proto_errs = 0;
  int max_level  = 0;
  logic prev_cs = 1'b1;

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      if (cs_rom && sclk_rom) proto_errs++;
      if ((cs_rom != prev_cs) && sclk_rom) proto_errs++;
    end
    prev_cs = cs_rom;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic        ds;
    logic [11:0] addr;
    int          gap;
    int          exp_lat;
    int          exp_cs_hi;   // -1 for hits (no chip-select expectation)
  } vec_t;

  vec_t       tv [$];
  logic [5:0] exp_q [$];

  task automatic do_fetch(input logic [11:0] a, output int lat, output int cs_hi,
                          output logic [5:0] d);
    bit seen_low;
    lat = 0; cs_hi = 0; seen_low = 0; d = '0;
    req_addr  = a;
    req_valid = 1'b1;
    while (lat < 2000) begin
      @(posedge clk); #1;
      lat++;
      if (!seen_low) begin
        if (cs_rom) cs_hi++;
        else seen_low = 1;
      end
      if (rsp_valid) begin
        d = rsp_data;
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat, cs_hi;
    logic [5:0]  d;
    logic [31:0] cmd;
    logic [31:0] exp_cmd;
    double_speed = v.ds;
    repeat (v.gap) begin @(posedge clk); #1; end
    exp_q.push_back(flash[v.addr][5:0]);
    do_fetch(v.addr, lat, cs_hi, d);
    check({tag, " latency"}, lat, v.exp_lat);
    check({tag, " data"}, int'(d), int'(exp_q.pop_front()));
    if (v.exp_cs_hi >= 0) begin
      exp_cmd = {20'h03000, v.addr};
      cmd = (cmd_q.size() > 0) ? cmd_q[$] : 32'hFFFF_FFFF;
      check({tag, " cs_high_cycles"}, cs_hi, v.exp_cs_hi);
      check({tag, " command"}, int'(cmd), int'(exp_cmd));
    end
  endtask

  initial begin
    int sclk_hi, cs_hi_cnt, lvl_bad, t;
    for (int i = 0; i < 4096; i++) flash[i] = 8'((i * 37) ^ (i >> 3));
    flash[12'h123] = 8'hA5;

    // Cold miss, sequential run at half speed, mid-byte jump, run up to the top address.
    tv.push_back('{1'b1, 12'h123, 0, 84, 2});
    tv.push_back('{1'b0, 12'h200, 2, 164, 2});
    for (int a = 12'h201; a <= 12'h20F; a++)
      tv.push_back('{1'b0, 12'(a), ((a - 12'h201) % 4 == 0) ? 150 : 0, 1, -1});
    tv.push_back('{1'b1, 12'h100, 10, 84, 2});
    tv.push_back('{1'b1, 12'h7FF, 5, 84, 2});
    tv.push_back('{1'b1, 12'hFFC, 5, 84, 2});
    tv.push_back('{1'b1, 12'hFFD, 60, 1, -1});
    tv.push_back('{1'b1, 12'hFFE, 0, 1, -1});
    tv.push_back('{1'b1, 12'hFFF, 0, 1, -1});

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; double_speed = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("reset cs_rom", int'(cs_rom), 1);
    check("reset sclk_rom", int'(sclk_rom), 0);
    check("reset rom_do", int'(rom_do), 0);
    check("reset rsp_valid", int'(rsp_valid), 0);
    check("reset fifo_level", int'(fifo_level), 0);
    rst = 1'b0;

    for (int i = 0; i < tv.size(); i++)
      run_vec(tv[i], $sformatf("vec%0d@%h", i, tv[i].addr));

    // Wrap pause: after 0xFFF the stream must stop for good.
    sclk_hi = 0; cs_hi_cnt = 0; lvl_bad = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (sclk_rom) sclk_hi++;
      if (cs_rom) cs_hi_cnt++;
      if (fifo_level != 3'd0) lvl_bad++;
    end
    check("wrap sclk_high_cycles", sclk_hi, 0);
    check("wrap cs_high_cycles", cs_hi_cnt, 0);
    check("wrap level_nonzero_cycles", lvl_bad, 0);
    run_vec('{1'b1, 12'h000, 0, 84, 2}, "wrap_miss@000");

    // Full FIFO held idle, then a head hit must resume streaming.
    repeat (200) begin @(posedge clk); #1; end
    sclk_hi = 0; cs_hi_cnt = 0; lvl_bad = 0;
    repeat (500) begin
      @(posedge clk); #1;
      if (sclk_rom) sclk_hi++;
      if (cs_rom) cs_hi_cnt++;
      if (fifo_level != 3'd4) lvl_bad++;
    end
    check("full sclk_high_cycles", sclk_hi, 0);
    check("full cs_high_cycles", cs_hi_cnt, 0);
    check("full level_not_4_cycles", lvl_bad, 0);
    run_vec('{1'b1, 12'h001, 0, 1, -1}, "full_hit@001");
    t = 0;
    while (t < 20) begin
      @(posedge clk); #1;
      t++;
      if (sclk_rom) break;
    end
    check("resume within 2k", int'(t <= 2), 1);

    // Reset in the middle of the address phase, then a cold miss.
    double_speed = 1'b1;
    req_addr = 12'h456; req_valid = 1'b1;
    repeat (25) begin @(posedge clk); #1; end
    check("pre-reset cs_rom", int'(cs_rom), 0);
    rst = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    check("midreset cs_rom", int'(cs_rom), 1);
    check("midreset sclk_rom", int'(sclk_rom), 0);
    check("midreset rom_do", int'(rom_do), 0);
    check("midreset rsp_valid", int'(rsp_valid), 0);
    check("midreset rsp_data", int'(rsp_data), 0);
    check("midreset fifo_level", int'(fifo_level), 0);
    rst = 1'b0;
    run_vec('{1'b1, 12'h123, 0, 84, 2}, "post_reset@123");

    check("protocol violations", proto_errs, 0);
    check("max fifo_level", max_level, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
